// File: rtl/dfii_csr_responder_if.sv
// Wishbone B4 classic bus bundle between the SoC crossbar (master) and the DFII CSR bank (slave).
interface dfii_csr_responder_if;
  localparam int unsigned WB_AW = 30;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = WB_DW / 8;

  logic [WB_AW-1:0] wb_adr;
  logic [WB_DW-1:0] wb_dat_w;
  logic [WB_DW-1:0] wb_dat_r;
  logic [WB_SW-1:0] wb_sel;
  logic             wb_cyc;
  logic             wb_stb;
  logic             wb_we;
  logic             wb_ack;

  modport slave (
    input  wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
    output wb_dat_r, wb_ack
  );

  modport master (
    output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
    input  wb_dat_r, wb_ack
  );
endinterface

// File: rtl/dfii_csr_responder.sv
// DFI-injector CSR bank: software-driven DDR3 init commands on DFI phase 0, with read-data capture
// and a read timeout flag, behind a Wishbone classic slave port.
module dfii_csr_responder #(
  parameter logic [29:0]  BASE_ADR   = 30'h2400,
  parameter int unsigned  ADDR_WIDTH = 14,
  parameter int unsigned  BANK_WIDTH = 3,
  parameter int unsigned  DATA_WIDTH = 32,
  parameter int unsigned  RD_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dfii_csr_responder_if.slave   wb,
  output logic                  dfi_sel,
  output logic                  dfi_cke,
  output logic                  dfi_odt,
  output logic                  dfi_reset_n,
  output logic                  dfi_cs_n,
  output logic                  dfi_ras_n,
  output logic                  dfi_cas_n,
  output logic                  dfi_we_n,
  output logic [ADDR_WIDTH-1:0] dfi_address,
  output logic [BANK_WIDTH-1:0] dfi_bank,
  output logic                  dfi_wrdata_en,
  output logic                  dfi_rddata_en,
  output logic [DATA_WIDTH-1:0] dfi_wrdata,
  input  logic [DATA_WIDTH-1:0] dfi_rddata,
  input  logic                  dfi_rddata_valid
);

  localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;

  // Phase-0 command held active-high internally so the all-zero reset value is a NOP.
  typedef struct packed {
    logic                  cs;
    logic                  ras;
    logic                  cas;
    logic                  we;
    logic                  wren;
    logic                  rden;
    logic [ADDR_WIDTH-1:0] address;
    logic [BANK_WIDTH-1:0] bank;
    logic [DATA_WIDTH-1:0] wrdata;
  } dfi_cmd_t;

  logic [1:0]            state_q,      state_d;
  logic [TW-1:0]         timer_q,      timer_d;
  logic [3:0]            ctrl_q,       ctrl_d;
  logic [5:0]            cmd_q,        cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
  logic [BANK_WIDTH-1:0] bank_q,       bank_d;
  logic [DATA_WIDTH-1:0] wrdata_q,     wrdata_d;
  logic [DATA_WIDTH-1:0] rddata_q,     rddata_d;
  logic                  rd_timeout_q, rd_timeout_d;
  logic                  ack_q,        ack_d;
  logic [31:0]           dat_r_q,      dat_r_d;
  dfi_cmd_t              dfi_q,        dfi_d;

  logic       hit_c;
  logic       acc_c;
  logic       wr_c;
  logic       rd_c;
  logic       busy_c;
  logic [3:0] off_c;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

  assign hit_c  = wb.wb_cyc & wb.wb_stb & (wb.wb_adr[29:4] == BASE_ADR[29:4]);
  assign acc_c  = hit_c & ~ack_q;
  assign wr_c   = acc_c & wb.wb_we;
  assign rd_c   = acc_c & ~wb.wb_we;
  assign off_c  = wb.wb_adr[3:0];
  assign busy_c = (state_q != S_IDLE);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    ctrl_d       = ctrl_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    bank_d       = bank_q;
    wrdata_d     = wrdata_q;
    rddata_d     = rddata_q;
    rd_timeout_d = rd_timeout_q;
    ack_d        = acc_c;
    dat_r_d      = '0;
    dfi_d        = '0;

    // Register reads; a STATUS read clears the sticky timeout flag.
    if (rd_c) begin
      unique case (off_c)
        4'd0:    dat_r_d = 32'(ctrl_q);
        4'd1:    dat_r_d = 32'(cmd_q);
        4'd3:    dat_r_d = 32'(addr_q);
        4'd4:    dat_r_d = 32'(bank_q);
        4'd5:    dat_r_d = 32'(wrdata_q);
        4'd6:    dat_r_d = 32'(rddata_q);
        4'd7:    dat_r_d = {30'd0, rd_timeout_q, busy_c};
        default: dat_r_d = '0;
      endcase
      if (off_c == 4'd7) rd_timeout_d = 1'b0;
    end

    if (wr_c) begin
      unique case (off_c)
        4'd0:    if (wb.wb_sel[0]) ctrl_d = wb.wb_dat_w[3:0];
        4'd1:    if (wb.wb_sel[0]) cmd_d  = wb.wb_dat_w[5:0];
        4'd3:    addr_d   = ADDR_WIDTH'(merge_bytes(32'(addr_q),   wb.wb_dat_w, wb.wb_sel));
        4'd4:    bank_d   = BANK_WIDTH'(merge_bytes(32'(bank_q),   wb.wb_dat_w, wb.wb_sel));
        4'd5:    wrdata_d = DATA_WIDTH'(merge_bytes(32'(wrdata_q), wb.wb_dat_w, wb.wb_sel));
        default: ;
      endcase
    end

    unique case (state_q)
      S_IDLE: begin
        if (wr_c && (off_c == 4'd2) && wb.wb_sel[0]) begin
          state_d       = S_ISSUE;
          dfi_d.cs      = cmd_q[0];
          dfi_d.we      = cmd_q[1];
          dfi_d.cas     = cmd_q[2];
          dfi_d.ras     = cmd_q[3];
          dfi_d.wren    = cmd_q[4];
          dfi_d.rden    = cmd_q[5];
          dfi_d.address = addr_q;
          dfi_d.bank    = bank_q;
          dfi_d.wrdata  = wrdata_q;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = dfi_q.rden ? S_RDWAIT : S_IDLE;
      end
      S_RDWAIT: begin
        if (dfi_rddata_valid) begin
          rddata_d = dfi_rddata;
          state_d  = S_IDLE;
        end else if (timer_q == TW'(RD_TIMEOUT - 1)) begin
          rd_timeout_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      ctrl_q       <= '0;
      cmd_q        <= '0;
      addr_q       <= '0;
      bank_q       <= '0;
      wrdata_q     <= '0;
      rddata_q     <= '0;
      rd_timeout_q <= 1'b0;
      ack_q        <= 1'b0;
      dat_r_q      <= '0;
      dfi_q        <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ctrl_q       <= ctrl_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      bank_q       <= bank_d;
      wrdata_q     <= wrdata_d;
      rddata_q     <= rddata_d;
      rd_timeout_q <= rd_timeout_d;
      ack_q        <= ack_d;
      dat_r_q      <= dat_r_d;
      dfi_q        <= dfi_d;
    end
  end

  assign wb.wb_ack   = ack_q;
  assign wb.wb_dat_r = dat_r_q;

  assign dfi_sel       = ctrl_q[0];
  assign dfi_cke       = ctrl_q[1];
  assign dfi_odt       = ctrl_q[2];
  assign dfi_reset_n   = ctrl_q[3];
  assign dfi_cs_n      = ~dfi_q.cs;
  assign dfi_ras_n     = ~dfi_q.ras;
  assign dfi_cas_n     = ~dfi_q.cas;
  assign dfi_we_n      = ~dfi_q.we;
  assign dfi_address   = dfi_q.address;
  assign dfi_bank      = dfi_q.bank;
  assign dfi_wrdata_en = dfi_q.wren;
  assign dfi_rddata_en = dfi_q.rden;
  assign dfi_wrdata    = dfi_q.wrdata;

endmodule

// File: tb/tb_dfii_csr_responder.sv
// Scoreboard bench for dfii_csr_responder: Wishbone reads and DFI command pulses are checked by
// independent monitors against expectations queued by the directed stimulus.
module tb_dfii_csr_responder;
  localparam logic [29:0] BASE = 30'h2400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dfi_sel, dfi_cke, dfi_odt, dfi_reset_n;
  logic        dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [13:0] dfi_address;
  logic [2:0]  dfi_bank;
  logic        dfi_wrdata_en, dfi_rddata_en;
  logic [31:0] dfi_wrdata;
  logic [31:0] dfi_rddata;
  logic        dfi_rddata_valid;

  always #5 clk = ~clk;

  dfii_csr_responder_if wb_if();

  dfii_csr_responder dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wb               (wb_if),
    .dfi_sel          (dfi_sel),
    .dfi_cke          (dfi_cke),
    .dfi_odt          (dfi_odt),
    .dfi_reset_n      (dfi_reset_n),
    .dfi_cs_n         (dfi_cs_n),
    .dfi_ras_n        (dfi_ras_n),
    .dfi_cas_n        (dfi_cas_n),
    .dfi_we_n         (dfi_we_n),
    .dfi_address      (dfi_address),
    .dfi_bank         (dfi_bank),
    .dfi_wrdata_en    (dfi_wrdata_en),
    .dfi_rddata_en    (dfi_rddata_en),
    .dfi_wrdata       (dfi_wrdata),
    .dfi_rddata       (dfi_rddata),
    .dfi_rddata_valid (dfi_rddata_valid)
  );

  typedef struct packed {
    logic        is_read;
    logic [31:0] data;
  } wb_exp_t;

  typedef struct packed {
    logic        cs, ras, cas, we, wren, rden;
    logic [13:0] addr;
    logic [2:0]  bank;
    logic [31:0] wrdata;
  } cmd_exp_t;

  wb_exp_t  wb_q[$];
  cmd_exp_t cmd_q[$];
  int       n_checks = 0;
  int       n_fail   = 0;
  int       cmd_seen = 0;
  logic     ack_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Wishbone monitor: every ack must be expected, single-cycle, and carry the queued read data.
  always @(negedge clk) begin
    if (!rst_n) begin
      ack_prev = 1'b0;
    end else begin
      if (wb_if.wb_ack) begin
        wb_exp_t e;
        check("ack_single_cycle", 64'(ack_prev), 64'd0);
        if (wb_q.size() == 0) fail_now("unexpected_ack");
        else begin
          e = wb_q.pop_front();
          if (e.is_read) check("wb_rd_data", 64'(wb_if.wb_dat_r), 64'(e.data));
        end
      end else if (ack_prev) begin
        check("dat_r_idle", 64'(wb_if.wb_dat_r), 64'd0);
      end
      ack_prev = wb_if.wb_ack;
    end
  end

  // DFI monitor: any non-NOP phase-0 cycle must match the next queued command.
  always @(negedge clk) begin
    if (rst_n) begin
      cmd_exp_t a;
      a = '{cs: ~dfi_cs_n, ras: ~dfi_ras_n, cas: ~dfi_cas_n, we: ~dfi_we_n,
            wren: dfi_wrdata_en, rden: dfi_rddata_en, addr: dfi_address,
            bank: dfi_bank, wrdata: dfi_wrdata};
      if (a.cs | a.ras | a.cas | a.we | a.wren | a.rden) begin
        cmd_seen++;
        if (cmd_q.size() == 0) fail_now("unexpected_dfi_cmd");
        else check("dfi_cmd", 64'(a), 64'(cmd_q.pop_front()));
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [29:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp_rd,
                         input bit expect_ack, input bit push);
    bit got;
    if (expect_ack && push) wb_q.push_back('{is_read: ~we, data: exp_rd});
    wb_if.wb_cyc   = 1'b1;
    wb_if.wb_stb   = 1'b1;
    wb_if.wb_we    = we;
    wb_if.wb_adr   = adr;
    wb_if.wb_dat_w = dat;
    wb_if.wb_sel   = sel;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (wb_if.wb_ack) got = 1'b1;
    end
    wb_if.wb_cyc = 1'b0;
    wb_if.wb_stb = 1'b0;
    wb_if.wb_we  = 1'b0;
    if (expect_ack && !got) fail_now("ack_timeout");
    if (!expect_ack) check("no_ack_outside_window", 64'(got), 64'd0);
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
    wb_xfer(1'b1, BASE + 30'(off), dat, sel, 32'd0, 1'b1, 1'b1);
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] exp);
    wb_xfer(1'b0, BASE + 30'(off), 32'd0, 4'hF, exp, 1'b1, 1'b1);
  endtask

  task automatic expect_cmd(input logic [5:0] cmd, input logic [13:0] addr,
                            input logic [2:0] bank, input logic [31:0] wdat);
    cmd_q.push_back('{cs: cmd[0], we: cmd[1], cas: cmd[2], ras: cmd[3], wren: cmd[4],
                      rden: cmd[5], addr: addr, bank: bank, wrdata: wdat});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    wb_if.wb_cyc     = 1'b0;
    wb_if.wb_stb     = 1'b0;
    wb_if.wb_we      = 1'b0;
    wb_if.wb_adr     = '0;
    wb_if.wb_dat_w   = '0;
    wb_if.wb_sel     = '0;
    dfi_rddata       = '0;
    dfi_rddata_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_static", 64'({dfi_reset_n, dfi_odt, dfi_cke, dfi_sel}), 64'h0);
    check("rst_cmd_n", 64'({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_wrdata_en, dfi_rddata_en}),
          64'b111100);
    check("rst_addr_bank_wdat", 64'({dfi_address, dfi_bank, dfi_wrdata}), 64'h0);
    check("rst_wb", 64'({wb_if.wb_ack, wb_if.wb_dat_r}), 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Static control bits follow CONTROL
    wr(4'd0, 32'h0C);
    check("ctrl_0c", 64'({dfi_reset_n, dfi_odt, dfi_cke, dfi_sel}), 64'b1100);
    wr(4'd0, 32'h0E);
    check("ctrl_0e", 64'({dfi_reset_n, dfi_odt, dfi_cke, dfi_sel}), 64'b1110);
    rd(4'd0, 32'h0E);

    // MR2
    wr(4'd5, 32'hA5A5_1234);
    wr(4'd3, 32'h200);
    wr(4'd4, 32'h2);
    wr(4'd1, 32'h0F);
    expect_cmd(6'h0F, 14'h200, 3'd2, 32'hA5A5_1234);
    wr(4'd2, 32'h1);
    repeat (3) @(posedge clk); #1;

    // Byte enables and sel[0]-only registers
    wr(4'd3, 32'h1FFF, 4'b0010);
    rd(4'd3, 32'h1F00);
    wr(4'd3, 32'h400);
    wr(4'd1, 32'h03);
    wr(4'd1, 32'h21, 4'b1110);
    rd(4'd1, 32'h03);

    // ZQCL
    expect_cmd(6'h03, 14'h400, 3'd2, 32'hA5A5_1234);
    wr(4'd2, 32'h1);
    repeat (3) @(posedge clk); #1;

    // Read with data returned five cycles after issue
    wr(4'd1, 32'h21);
    expect_cmd(6'h21, 14'h400, 3'd2, 32'hA5A5_1234);
    wr(4'd2, 32'h1);
    repeat (5) @(posedge clk);
    #1 dfi_rddata = 32'hFACE_CA8C; dfi_rddata_valid = 1'b1;
    @(posedge clk);
    #1 dfi_rddata_valid = 1'b0;
    rd(4'd6, 32'hFACE_CA8C);
    rd(4'd7, 32'h0);

    // Stray valid while idle is ignored
    dfi_rddata = 32'hDEAD_BEEF; dfi_rddata_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 dfi_rddata_valid = 1'b0;
    rd(4'd6, 32'hFACE_CA8C);

    // Read timeout, with a second ISSUE while busy that must not fire
    expect_cmd(6'h21, 14'h400, 3'd2, 32'hA5A5_1234);
    wr(4'd2, 32'h1);
    rd(4'd7, 32'h1);
    wr(4'd2, 32'h1);
    repeat (70) @(posedge clk); #1;
    rd(4'd7, 32'h2);
    rd(4'd7, 32'h0);

    // Unmapped offset inside the window, and an address outside it
    wr(4'd9, 32'h1234_5678);
    rd(4'd9, 32'h0);
    wb_xfer(1'b0, 30'h3000, 32'd0, 4'hF, 32'd0, 1'b0, 1'b0);
    wb_xfer(1'b1, 30'h3000, 32'h5, 4'hF, 32'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an ISSUE cycle
    wr(4'd1, 32'h0F);
    wb_xfer(1'b1, BASE + 30'd2, 32'h1, 4'hF, 32'd0, 1'b1, 1'b0);
    check("mid_issue_cs_n", 64'(dfi_cs_n), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_cmd_n", 64'({dfi_cs_n, dfi_ras_n, dfi_cas_n, dfi_we_n, dfi_wrdata_en, dfi_rddata_en}),
          64'b111100);
    check("rst_mid_static", 64'({dfi_reset_n, dfi_odt, dfi_cke, dfi_sel}), 64'h0);
    check("rst_mid_addr", 64'({dfi_address, dfi_bank, dfi_wrdata}), 64'h0);
    check("rst_mid_wb", 64'({wb_if.wb_ack, wb_if.wb_dat_r}), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    rd(4'd7, 32'h0);
    rd(4'd3, 32'h0);
    repeat (3) @(posedge clk); #1;

    check("dfi_cmd_count", 64'(cmd_seen), 64'd4);
    check("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
    check("wb_queue_drained", 64'(wb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
